// File: rtl/ex_div_stage_pkg.sv
// ---------------------------------------------------------------------------
// ex_div_stage_pkg
// Shared definitions for the EX stage: operation / result-class codes,
// register-address constants, divider FSM state encoding and the divider
// ready flag values. No ports (package).
// ---------------------------------------------------------------------------
package ex_div_stage_pkg;

  localparam int ALU_OP_W   = 8;
  localparam int ALU_SEL_W  = 3;
  localparam int REG_ADDR_W = 5;

  typedef logic [ALU_OP_W-1:0]   alu_op_t;
  typedef logic [ALU_SEL_W-1:0]  alu_sel_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Operation codes
  localparam alu_op_t EXE_NOP_OP  = 8'b0000_0000;
  localparam alu_op_t EXE_AND_OP  = 8'b0010_0100;
  localparam alu_op_t EXE_OR_OP   = 8'b0010_0101;
  localparam alu_op_t EXE_XOR_OP  = 8'b0010_0110;
  localparam alu_op_t EXE_NOR_OP  = 8'b0010_0111;
  localparam alu_op_t EXE_SLL_OP  = 8'b0111_1100;
  localparam alu_op_t EXE_SRL_OP  = 8'b0000_0010;
  localparam alu_op_t EXE_SRA_OP  = 8'b0000_0011;
  localparam alu_op_t EXE_SLT_OP  = 8'b0010_1010;
  localparam alu_op_t EXE_SLTU_OP = 8'b0010_1011;
  localparam alu_op_t EXE_ADDU_OP = 8'b0010_0001;
  localparam alu_op_t EXE_SUBU_OP = 8'b0010_0011;
  localparam alu_op_t EXE_MFHI_OP = 8'b0001_0000;
  localparam alu_op_t EXE_MTHI_OP = 8'b0001_0001;
  localparam alu_op_t EXE_MFLO_OP = 8'b0001_0010;
  localparam alu_op_t EXE_MTLO_OP = 8'b0001_0011;
  localparam alu_op_t EXE_DIV_OP  = 8'b0001_1010;
  localparam alu_op_t EXE_DIVU_OP = 8'b0001_1011;

  // Result classes
  localparam alu_sel_t EXE_RES_NOP   = 3'b000;
  localparam alu_sel_t EXE_RES_LOGIC = 3'b001;
  localparam alu_sel_t EXE_RES_SHIFT = 3'b010;
  localparam alu_sel_t EXE_RES_MOVE  = 3'b011;
  localparam alu_sel_t EXE_RES_ARITH = 3'b100;

  localparam reg_addr_t NOP_REG_ADDR  = '0;
  localparam logic      WRITE_DISABLE = 1'b0;
  localparam logic      WRITE_ENABLE  = 1'b1;

  // Divider FSM states
  typedef enum logic [1:0] {
    DivIdle   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  function automatic logic is_div_op(input alu_op_t op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/ex_div_stage_if.sv
// ---------------------------------------------------------------------------
// ex_div_stage_if
// Bundles the ID/EX-side inputs, CTRL handshake and EX/MEM-side outputs of
// the execute stage.
//   master : pipeline side (drives ID/EX fields, stall/annul; reads results)
//   slave  : execute stage (reads ID/EX fields; drives results, stallreq_o)
// ---------------------------------------------------------------------------
interface ex_div_stage_if #(parameter int DATA_W = 32);
  import ex_div_stage_pkg::*;

  alu_op_t           aluop_i;
  alu_sel_t          alusel_i;
  logic [DATA_W-1:0] reg1_i;
  logic [DATA_W-1:0] reg2_i;
  reg_addr_t         wd_i;
  logic              wreg_i;
  logic [DATA_W-1:0] hi_i;
  logic [DATA_W-1:0] lo_i;
  logic              stall_i;
  logic              annul_i;

  reg_addr_t         wd_o;
  logic              wreg_o;
  logic [DATA_W-1:0] wdata_o;
  logic              whilo_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic              stallreq_o;

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i,
           stall_i, annul_i,
    input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i,
           stall_i, annul_i,
    output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );

endinterface

// File: rtl/ex_div_stage_div.sv
// ---------------------------------------------------------------------------
// ex_div_stage_div
// Multi-cycle radix-2 restoring divider (one quotient bit per clock).
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   start            begin a division (only honoured in DivIdle)
//   signed_div       treat operands as two's complement
//   opdata1/opdata2  dividend / divisor
//   annul            abandon any division, back to DivIdle
//   hold             keep the result stable while in DivEnd
//   result           {remainder, quotient}, valid while ready
//   ready            DivResultReady in DivEnd
// ---------------------------------------------------------------------------
module ex_div_stage_div
  import ex_div_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                signed_div,
  input  logic [DATA_W-1:0]   opdata1,
  input  logic [DATA_W-1:0]   opdata2,
  input  logic                annul,
  input  logic                hold,
  output logic [2*DATA_W-1:0] result,
  output logic                ready
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  div_state_e          state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [DATA_W-1:0]   dividend_reg;
  logic [DATA_W-1:0]   divisor_reg;   // magnitude
  logic [DATA_W-1:0]   quo_reg;       // shifts dividend out, quotient in
  logic [DATA_W-1:0]   rem_reg;       // partial remainder
  logic                neg_quo_reg;
  logic                neg_rem_reg;
  logic [2*DATA_W-1:0] result_reg;

  logic [DATA_W-1:0] mag1, mag2;
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] quo_next, rem_next, quo_fix, rem_fix;

  assign mag1 = (signed_div && opdata1[DATA_W-1]) ? -opdata1 : opdata1;
  assign mag2 = (signed_div && opdata2[DATA_W-1]) ? -opdata2 : opdata2;

  // A borrow out of the trial subtraction means the shifted remainder is
  // smaller than the divisor: keep it (restore) and shift in a 0.
  always_comb begin
    trial = {rem_reg, quo_reg[DATA_W-1]} - {1'b0, divisor_reg};
    if (trial[DATA_W]) begin
      rem_next = {rem_reg[DATA_W-2:0], quo_reg[DATA_W-1]};
      quo_next = {quo_reg[DATA_W-2:0], 1'b0};
    end else begin
      rem_next = trial[DATA_W-1:0];
      quo_next = {quo_reg[DATA_W-2:0], 1'b1};
    end
    quo_fix = neg_quo_reg ? -quo_next : quo_next;
    rem_fix = neg_rem_reg ? -rem_next : rem_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= DivIdle;
      cnt_reg      <= '0;
      dividend_reg <= '0;
      divisor_reg  <= '0;
      quo_reg      <= '0;
      rem_reg      <= '0;
      neg_quo_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
      result_reg   <= '0;
    end else if (annul) begin
      state_reg <= DivIdle;
      cnt_reg   <= '0;
    end else begin
      unique case (state_reg)
        DivIdle: begin
          if (start) begin
            dividend_reg <= opdata1;
            divisor_reg  <= mag2;
            quo_reg      <= mag1;
            rem_reg      <= '0;
            cnt_reg      <= '0;
            neg_quo_reg  <= signed_div && (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
            neg_rem_reg  <= signed_div && opdata1[DATA_W-1];
            state_reg    <= (opdata2 == '0) ? DivByZero : DivOn;
          end
        end
        DivOn: begin
          quo_reg <= quo_next;
          rem_reg <= rem_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_STEP) begin
            result_reg <= {rem_fix, quo_fix};
            state_reg  <= DivEnd;
          end
        end
        DivByZero: begin
          result_reg <= {dividend_reg, {DATA_W{1'b1}}};
          state_reg  <= DivEnd;
        end
        DivEnd: begin
          if (!hold) state_reg <= DivIdle;
        end
        default: state_reg <= DivIdle;
      endcase
    end
  end

  assign result = result_reg;
  assign ready  = (state_reg == DivEnd) ? DivResultReady : DivResultNotReady;

endmodule

// File: rtl/ex_div_stage.sv
// ---------------------------------------------------------------------------
// ex_div_stage
// Execute stage: single-cycle logic/shift/arith/move ALU plus a multi-cycle
// divider for DIV/DIVU that holds the front of the pipeline via stallreq_o.
// Ports:
//   clk   pipeline clock
//   rst   asynchronous active-low reset; forces all outputs to idle values
//   bus   ex_div_stage_if.slave (ID/EX inputs, CTRL stall/annul, EX/MEM
//         outputs and stallreq_o)
// ---------------------------------------------------------------------------
module ex_div_stage
  import ex_div_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  ex_div_stage_if.slave bus
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0]   reg1, reg2;
  logic [SH_W-1:0]     shamt;
  logic                lt_signed, lt_unsigned;
  logic                div_op, div_signed, div_start, div_ready;
  logic [2*DATA_W-1:0] div_result;
  logic [DATA_W-1:0]   wdata_c, hi_c, lo_c;
  logic                whilo_c;

  assign reg1        = bus.reg1_i;
  assign reg2        = bus.reg2_i;
  assign shamt       = reg1[SH_W-1:0];
  assign lt_signed   = $signed(reg1) < $signed(reg2);
  assign lt_unsigned = reg1 < reg2;

  assign div_op     = is_div_op(bus.aluop_i);
  assign div_signed = (bus.aluop_i == EXE_DIV_OP);
  assign div_start  = div_op && !bus.annul_i;

  ex_div_stage_div #(.DATA_W(DATA_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start      (div_start),
    .signed_div (div_signed),
    .opdata1    (reg1),
    .opdata2    (reg2),
    .annul      (bus.annul_i),
    .hold       (bus.stall_i),
    .result     (div_result),
    .ready      (div_ready)
  );

  always_comb begin : result_mux
    wdata_c = '0;
    case (bus.alusel_i)
      EXE_RES_LOGIC: begin
        case (bus.aluop_i)
          EXE_OR_OP:  wdata_c = reg1 | reg2;
          EXE_AND_OP: wdata_c = reg1 & reg2;
          EXE_XOR_OP: wdata_c = reg1 ^ reg2;
          EXE_NOR_OP: wdata_c = ~(reg1 | reg2);
          default:    wdata_c = '0;
        endcase
      end
      EXE_RES_SHIFT: begin
        case (bus.aluop_i)
          EXE_SLL_OP: wdata_c = reg2 << shamt;
          EXE_SRL_OP: wdata_c = reg2 >> shamt;
          EXE_SRA_OP: wdata_c = $unsigned($signed(reg2) >>> shamt);
          default:    wdata_c = '0;
        endcase
      end
      EXE_RES_ARITH: begin
        case (bus.aluop_i)
          EXE_ADDU_OP: wdata_c = reg1 + reg2;
          EXE_SUBU_OP: wdata_c = reg1 - reg2;
          EXE_SLT_OP:  wdata_c = {{(DATA_W-1){1'b0}}, lt_signed};
          EXE_SLTU_OP: wdata_c = {{(DATA_W-1){1'b0}}, lt_unsigned};
          default:     wdata_c = '0;
        endcase
      end
      EXE_RES_MOVE: begin
        case (bus.aluop_i)
          EXE_MFHI_OP: wdata_c = bus.hi_i;
          EXE_MFLO_OP: wdata_c = bus.lo_i;
          default:     wdata_c = '0;
        endcase
      end
      default: wdata_c = '0;
    endcase
  end

  always_comb begin : hilo_mux
    whilo_c = 1'b0;
    hi_c    = '0;
    lo_c    = '0;
    if (div_op) begin
      if (div_ready == DivResultReady) begin
        whilo_c = 1'b1;
        hi_c    = div_result[2*DATA_W-1:DATA_W];
        lo_c    = div_result[DATA_W-1:0];
      end
    end else if (bus.aluop_i == EXE_MTHI_OP) begin
      whilo_c = 1'b1;
      hi_c    = reg1;
      lo_c    = bus.lo_i;
    end else if (bus.aluop_i == EXE_MTLO_OP) begin
      whilo_c = 1'b1;
      hi_c    = bus.hi_i;
      lo_c    = reg1;
    end
  end

  // Stall covers the start cycle (IDLE + div op) and every busy cycle; it
  // drops as soon as the divider reports ready. stall_i never feeds it.
  assign bus.stallreq_o = rst && div_op && (div_ready != DivResultReady);

  // Reset forces the idle output values directly, independent of the clock.
  assign bus.wd_o    = rst ? bus.wd_i   : NOP_REG_ADDR;
  assign bus.wreg_o  = rst ? bus.wreg_i : WRITE_DISABLE;
  assign bus.wdata_o = rst ? wdata_c    : '0;
  assign bus.whilo_o = rst && whilo_c;
  assign bus.hi_o    = rst ? hi_c       : '0;
  assign bus.lo_o    = rst ? lo_c       : '0;

endmodule

// File: doc/ex_div_stage.md
# ex_div_stage

Execute stage of the five-stage integer pipeline. It consumes the decoded operation, operands and destination registered by the ID/EX pipeline register and produces the register-file write result for the EX/MEM register. It also produces HI/LO write data. Single-cycle ALU operations complete combinationally. DIV/DIVU run on a multi-cycle radix-2 divider that raises a stall request to CTRL until the quotient and remainder are ready.

## Interface
Parameters:
- DATA_W, 32, operand/result width; the divider iteration count equals DATA_W.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- aluop_i  in  `AluOpBus`  operation from ID/EX
- alusel_i  in  `AluSelBus`  result class from ID/EX
- reg1_i / reg2_i  in  DATA_W  source operands (rs, rt)
- wd_i  in  `RegAddrBus`  destination register
- wreg_i  in  1  destination write enable
- hi_i / lo_i  in  DATA_W  current HI/LO, already forwarded
- stall_i  in  1  CTRL stall[3]; EX/MEM frozen
- annul_i  in  1  flush; abandon any division in progress
- wd_o  out  `RegAddrBus`  = wd_i
- wreg_o  out  1  = wreg_i
- wdata_o  out  DATA_W  result selected by alusel_i
- whilo_o  out  1  HI/LO write enable
- hi_o / lo_o  out  DATA_W  HI/LO write data
- stallreq_o  out  1  request to CTRL to freeze PC through ID/EX

## Operation
- Logic (`EXE_RES_LOGIC`): OR, AND, XOR, NOR on reg1_i/reg2_i.
- Shift (`EXE_RES_SHIFT`): SLL, SRL, SRA of reg2_i by reg1_i[4:0].
- Arithmetic (`EXE_RES_ARITH`): ADDU, SUBU (mod 2^32); SLT signed compare, SLTU unsigned compare, result 0/1.
- Move (`EXE_RES_MOVE`): MFHI → wdata_o = hi_i; MFLO → lo_i. MTHI → whilo_o=1, hi_o=reg1_i, lo_o=lo_i. MTLO → symmetric.
- `EXE_RES_NOP` or an unknown aluop: wdata_o = 0, whilo_o = 0.
- DIV/DIVU: whilo_o=1, hi_o=remainder, lo_o=quotient, only in state DONE.
- Divider FSM states, encoded in `defines.h`:
  - IDLE: if aluop_i ∈ {DIV, DIVU} and annul_i=0, latch the operands.
    - Divisor 0 → next state DBZ.
    - Otherwise → DIVIDING, counter=0.
    - stallreq_o=1 in the cycle a division starts.
  - DIVIDING: one restoring step per cycle on magnitudes; counter++. After DATA_W steps → DONE. stallreq_o=1.
  - DBZ: quotient forced to all-ones, remainder = dividend → DONE. stallreq_o=1.
  - DONE: results valid, stallreq_o=0. Stay in DONE while stall_i=1; otherwise → IDLE.
- Signed DIV: divide |a| by |b|.
  - Negate the quotient if the signs differ.
  - The remainder takes the dividend's sign.
  - 0x80000000 / -1 yields quotient 0x80000000, remainder 0. No trap.
- annul_i=1 in any state → IDLE at the next edge. The FSM does not assert stallreq_o in the following cycle.
- Reset: state IDLE, counter 0, operand/partial registers 0.
  - Outputs during reset: stallreq_o=0, whilo_o=0, hi_o=lo_o=0, wdata_o=0, wd_o=`NOPRegAddr`, wreg_o=`WriteDisable`.
  - Reset mid-division discards the division.

## Timing
- Non-divide ops: zero latency (combinational from the ID/EX outputs); stallreq_o=0.
- DIV entering EX at cycle 0:
  - stallreq_o=1 in cycles 0..DATA_W, i.e. 0..32.
  - DONE in cycle 33 with stallreq_o=0 and whilo_o=1. EX/MEM captures at the end of cycle 33.
- Divide-by-zero: stallreq_o=1 in cycles 0..1; DONE in cycle 2.
- Back-to-back DIVs: the second division starts in the cycle after DONE, from IDLE. No division starts while in DONE.
- stallreq_o and whilo_o are decoded from the registered state plus the aluop_i decode. There is no combinational path from stall_i to stallreq_o.

## Structure
- `defines.h` holds:
  - `EXE_DIV_OP`, `EXE_DIVU_OP` and the remaining op/sel codes;
  - the FSM state encodings `DivIdle`, `DivOn`, `DivByZero`, `DivEnd`;
  - `DivResultReady`.
- Sub-module `div`: owns the FSM, counter, partial remainder and sign fix-up. Its interface is start/signed/opdata1/opdata2/annul/hold → result[63:0]/ready.
- The top level holds the combinational ALU, the result mux, and the glue between stallreq_o and div.ready.

## Test plan
- OR 0x0000FF00, 0x00F000F0 → wdata_o=0x00F0FFF0. SRA 0x80000000 by 4 → 0xF8000000. SLT -1,1 → 1. SLTU -1,1 → 0.
- DIVU 100/7 at cycle 0 → stallreq_o high cycles 0..32; cycle 33: lo_o=14, hi_o=2, whilo_o=1, stallreq_o=0.
- DIV -7/2 → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV 0x80000000/-1 → lo_o=0x80000000, hi_o=0.
- DIV 5/0 → DONE at cycle 2, lo_o=0xFFFFFFFF, hi_o=5.
- annul_i at cycle 10 of a division → stallreq_o=0 from cycle 11, whilo_o never asserted. rst low at cycle 10 → every output returns to its reset value immediately.
- stall_i held 3 cycles while in DONE → hi_o/lo_o/whilo_o stable for 4 cycles. A second DIVU presented next → starts from IDLE, correct result 34 cycles later.
